// File: rtl/mt_pkg.sv
// Shared constants and state type for the Mersenne Twister cores.
// The defaults give bit-exact MT19937.
package mt_pkg;

  localparam int          MT_W = 32;
  localparam int          MT_N = 624;
  localparam int          MT_M = 397;
  localparam int          MT_R = 31;
  localparam logic [31:0] MT_A = 32'h9908B0DF;
  localparam logic [31:0] MT_F = 32'h6C078965;
  localparam int          MT_U = 11;
  localparam int          MT_S = 7;
  localparam logic [31:0] MT_B = 32'h9D2C5680;
  localparam int          MT_T = 15;
  localparam logic [31:0] MT_C = 32'hEFC60000;
  localparam int          MT_L = 18;

  localparam int IDX_W = $clog2(MT_N);

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_SEED     = 2'd1,
    ST_RUN      = 2'd2
  } mt_state_e;

endpackage

// File: rtl/mt_temper.sv
// Combinational MT output tempering; the D mask is all-ones and so omitted.
module mt_temper #(
  parameter int             W = 32,
  parameter int             U = 11,
  parameter int             S = 7,
  parameter logic [W-1:0]   B = 32'h9D2C5680,
  parameter int             T = 15,
  parameter logic [W-1:0]   C = 32'hEFC60000,
  parameter int             L = 18
) (
  input  logic [W-1:0] i_word,
  output logic [W-1:0] o_word
);

  logic [W-1:0] w_z1;
  logic [W-1:0] w_z2;
  logic [W-1:0] w_z3;

  assign w_z1   = i_word ^ (i_word >> U);
  assign w_z2   = w_z1 ^ ((w_z1 << S) & B);
  assign w_z3   = w_z2 ^ ((w_z2 << T) & C);
  assign o_word = w_z3 ^ (w_z3 >> L);

endmodule

// File: rtl/mt_prng_core.sv
// Stallable, reseedable Mersenne Twister: in-place circular state, internal
// seed expansion, one tempered word per cycle over a valid/ready output.
module mt_prng_core
  import mt_pkg::*;
#(
  parameter int           W = MT_W,
  parameter int           N = MT_N,
  parameter int           M = MT_M,
  parameter int           R = MT_R,
  parameter logic [W-1:0] A = MT_A,
  parameter logic [W-1:0] F = MT_F,
  parameter int           U = MT_U,
  parameter int           S = MT_S,
  parameter logic [W-1:0] B = MT_B,
  parameter int           T = MT_T,
  parameter logic [W-1:0] C = MT_C,
  parameter int           L = MT_L
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         seed_start,
  input  logic [W-1:0] seed,
  output logic         busy,
  output logic         seeded,
  input  logic         rv_ready,
  output logic         rv_valid,
  output logic [W-1:0] rv,
  output logic [1:0]   dbg_state
);

  // Handshake: a word transfers on any edge where rv_valid && rv_ready; while
  // rv_valid && !rv_ready, rv and rv_valid hold; rv_ready is ignored otherwise.

  localparam int           IW         = $clog2(N);
  localparam logic [W-1:0] LOWER_MASK = {{(W-R){1'b0}}, {R{1'b1}}};
  localparam logic [IW-1:0] LAST      = IW'(N - 1);
  localparam logic [IW:0]  N_EXT      = (IW+1)'(N);
  localparam logic [IW:0]  M_EXT      = (IW+1)'(M);

  mt_state_e     r_state;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_prev;
  logic [W-1:0]  r_mt [N];

  logic [IW-1:0] w_idx1;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idxm;
  logic [W-1:0]  w_y;
  logic [W-1:0]  w_twist;
  logic [W-1:0]  w_tempered;
  logic [W-1:0]  w_seed_word;
  logic          w_step;

  assign w_idx1 = (r_idx == LAST) ? '0 : r_idx + IW'(1);
  assign w_sum  = {1'b0, r_idx} + M_EXT;
  assign w_idxm = (w_sum >= N_EXT) ? IW'(w_sum - N_EXT) : IW'(w_sum);

  assign w_y     = (r_mt[r_idx] & ~LOWER_MASK) | (r_mt[w_idx1] & LOWER_MASK);
  assign w_twist = r_mt[w_idxm] ^ (w_y >> 1) ^ (w_y[0] ? A : '0);

  // r_prev mirrors the last seeded word so seeding needs no extra read port.
  assign w_seed_word = F * (r_prev ^ (r_prev >> (W-2))) + W'(r_idx);

  assign w_step    = (r_state == ST_RUN) && (!rv_valid || rv_ready);
  assign busy      = (r_state == ST_SEED);
  assign dbg_state = r_state;

  mt_temper #(
    .W(W), .U(U), .S(S), .B(B), .T(T), .C(C), .L(L)
  ) u_temper (
    .i_word (w_twist),
    .o_word (w_tempered)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= ST_UNSEEDED;
      r_idx    <= '0;
      r_prev   <= '0;
      seeded   <= 1'b0;
      rv_valid <= 1'b0;
      rv       <= '0;
    end else if (seed_start) begin
      r_state  <= ST_SEED;
      r_idx    <= IW'(1);
      r_prev   <= seed;
      seeded   <= 1'b0;
      rv_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_SEED: begin
          r_prev <= w_seed_word;
          if (r_idx == LAST) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
            seeded  <= 1'b1;
          end else begin
            r_idx <= w_idx1;
          end
        end
        ST_RUN: begin
          if (w_step) begin
            rv       <= w_tempered;
            rv_valid <= 1'b1;
            r_idx    <= w_idx1;
          end else begin
            rv_valid <= rv_valid && !rv_ready;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (seed_start) begin
      r_mt[0] <= seed;
    end else if (r_state == ST_SEED) begin
      r_mt[r_idx] <= w_seed_word;
    end else if (w_step) begin
      r_mt[r_idx] <= w_twist;
    end
  end

endmodule

// File: tb/tb_mt_prng_core.sv
// Bench for mt_prng_core: MT19937 instance plus a W=16/N=32/M=13 instance,
// both checked against an array-based MT reference model via scoreboards.
module tb_mt_prng_core;
  import mt_pkg::*;

  // Index 0: MT19937 defaults; index 1: small 16-bit variant.
  localparam int CW[2] = '{32, 16};
  localparam int CN[2] = '{624, 32};
  localparam int CM[2] = '{397, 13};
  localparam int CR[2] = '{31, 15};
  localparam int CU[2] = '{11, 5};
  localparam int CS[2] = '{7, 3};
  localparam int CT[2] = '{15, 7};
  localparam int CL[2] = '{18, 8};
  localparam longint unsigned CA[2] = '{64'h9908B0DF, 64'hB5C3};
  localparam longint unsigned CF[2] = '{64'h6C078965, 64'h8965};
  localparam longint unsigned CB[2] = '{64'h9D2C5680, 64'h9D2C};
  localparam longint unsigned CC[2] = '{64'hEFC60000, 64'hEFC0};

  localparam logic [31:0] GOLD5[5] = '{32'd3499211612, 32'd581869302,
                                      32'd3890346734, 32'd3586334585,
                                      32'd545404204};

  // ---------------- clock / reset ----------------
  logic clk;
  logic n_rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        ss0, rr0, busy0, seeded0, rv_valid0;
  logic [31:0] sd0, rv0;
  logic [1:0]  dbg0;
  logic        ss1, rr1, busy1, seeded1, rv_valid1;
  logic [15:0] sd1, rv1;
  logic [1:0]  dbg1;

  mt_prng_core u_dut0 (
    .clk(clk), .n_rst(n_rst), .seed_start(ss0), .seed(sd0),
    .busy(busy0), .seeded(seeded0), .rv_ready(rr0), .rv_valid(rv_valid0),
    .rv(rv0), .dbg_state(dbg0)
  );

  mt_prng_core #(
    .W(16), .N(32), .M(13), .R(15), .A(16'hB5C3), .F(16'h8965),
    .U(5), .S(3), .B(16'h9D2C), .T(7), .C(16'hEFC0), .L(8)
  ) u_dut1 (
    .clk(clk), .n_rst(n_rst), .seed_start(ss1), .seed(sd1),
    .busy(busy1), .seeded(seeded1), .rv_ready(rr1), .rv_valid(rv_valid1),
    .rv(rv1), .dbg_state(dbg1)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int acc0  = 0;
  int acc1  = 0;
  bit gold_on = 1'b0;

  logic [31:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  function automatic void chk(input string nm, input longint unsigned act,
                              input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  longint unsigned m_mt[2][624];
  int              m_i[2];

  function automatic longint unsigned msk_of(input int c);
    return (64'd1 << CW[c]) - 64'd1;
  endfunction

  function automatic void m_seed(input int c, input longint unsigned s);
    longint unsigned msk;
    longint unsigned p;
    msk = msk_of(c);
    m_mt[c][0] = s & msk;
    for (int i = 1; i < CN[c]; i++) begin
      p = m_mt[c][i-1];
      m_mt[c][i] = (CF[c] * (p ^ (p >> (CW[c] - 2))) + longint'(i)) & msk;
    end
    m_i[c] = 0;
  endfunction

  function automatic longint unsigned m_next(input int c);
    longint unsigned msk, lo, up, y, z;
    int i, n;
    i   = m_i[c];
    n   = CN[c];
    msk = msk_of(c);
    lo  = (64'd1 << CR[c]) - 64'd1;
    up  = msk & ~lo;
    y   = (m_mt[c][i] & up) | (m_mt[c][(i + 1) % n] & lo);
    m_mt[c][i] = m_mt[c][(i + CM[c]) % n] ^ (y >> 1) ^ (((y & 64'd1) != 0) ? CA[c] : 64'd0);
    z = m_mt[c][i];
    z = z ^ (z >> CU[c]);
    z = z ^ ((z << CS[c]) & CB[c]);
    z = z ^ ((z << CT[c]) & CC[c]);
    z = z ^ (z >> CL[c]);
    m_i[c] = (i + 1) % n;
    return z & msk;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (n_rst && !ss0 && rv_valid0) begin
      if (exp_q0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rv0_unexpected actual=%0d required=no_word", rv0);
      end else begin
        chk("rv0", rv0, exp_q0[0]);
        if (rr0) begin
          void'(exp_q0.pop_front());
          acc0++;
          if (gold_on && acc0 <= 5) chk("rv0_gold_first5", rv0, GOLD5[acc0-1]);
          if (gold_on && acc0 == 10000) chk("rv0_gold_10000", rv0, 32'd4123659995);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst && !ss1 && rv_valid1) begin
      if (exp_q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rv1_unexpected actual=%0d required=no_word", rv1);
      end else begin
        chk("rv1", rv1, exp_q1[0]);
        if (rr1) begin
          void'(exp_q1.pop_front());
          acc1++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic get_valid(input int c);
    return (c == 0) ? rv_valid0 : rv_valid1;
  endfunction

  function automatic logic get_busy(input int c);
    return (c == 0) ? busy0 : busy1;
  endfunction

  function automatic logic get_seeded(input int c);
    return (c == 0) ? seeded0 : seeded1;
  endfunction

  task automatic set_ready(input int c, input logic r);
    if (c == 0) rr0 = r;
    else        rr1 = r;
  endtask

  // Issue a one-cycle seed request and queue the k+1 words that must follow.
  task automatic reseed(input int c, input logic [31:0] s, input int k);
    longint unsigned v;
    m_seed(c, longint'(s));
    if (c == 0) begin
      exp_q0.delete();
      for (int j = 0; j <= k; j++) begin
        v = m_next(0);
        exp_q0.push_back(32'(v));
      end
      acc0    = 0;
      gold_on = (s == 32'd5489);
      ss0 = 1'b1; sd0 = s; rr0 = 1'b0;
    end else begin
      exp_q1.delete();
      for (int j = 0; j <= k; j++) begin
        v = m_next(1);
        exp_q1.push_back(16'(v));
      end
      acc1 = 0;
      ss1 = 1'b1; sd1 = s[15:0]; rr1 = 1'b0;
    end
    @(posedge clk); #1;
    if (c == 0) ss0 = 1'b0;
    else        ss1 = 1'b0;
  endtask

  // Called right after the seed edge: checks busy length and first-valid edge.
  task automatic wait_run(input int c);
    int busy_cyc;
    int first_edge;
    busy_cyc   = 0;
    first_edge = -1;
    chk("seeded_low_while_seeding", get_seeded(c), 0);
    if (get_busy(c)) busy_cyc++;
    for (int e = 1; e <= CN[c] + 50; e++) begin
      @(posedge clk); #1;
      if (get_busy(c)) busy_cyc++;
      if (get_valid(c)) begin
        first_edge = e;
        break;
      end
    end
    chk("busy_cycles", busy_cyc, CN[c] - 1);
    chk("first_valid_edge", first_edge, CN[c]);
    chk("seeded_after_seeding", get_seeded(c), 1);
  endtask

  task automatic stream(input int c, input int k, input bit stall);
    int stall_cnt;
    int acc;
    logic r;
    stall_cnt = 0;
    for (int cyc = 0; cyc < k * 30 + 2000; cyc++) begin
      acc = (c == 0) ? acc0 : acc1;
      if (acc >= k) break;
      r = 1'b1;
      if (stall) begin
        if (stall_cnt > 0) begin
          stall_cnt--;
          r = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          stall_cnt = $urandom_range(1, 25);
          r = 1'b0;
        end else begin
          r = 1'($urandom_range(0, 1));
        end
      end
      set_ready(c, r);
      @(posedge clk); #1;
    end
    set_ready(c, 1'b0);
    acc = (c == 0) ? acc0 : acc1;
    chk("stream_words_accepted", acc, k);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] s_small;
    int seen0, seen1;
    n_rst = 1'b0;
    ss0 = 1'b0; sd0 = '0; rr0 = 1'b0;
    ss1 = 1'b0; sd1 = '0; rr1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy0", busy0, 0);
    chk("rst_seeded0", seeded0, 0);
    chk("rst_valid0", rv_valid0, 0);
    chk("rst_rv0", rv0, 0);
    chk("rst_state0", dbg0, ST_UNSEEDED);
    chk("rst_valid1", rv_valid1, 0);
    n_rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("unseeded_no_valid0", rv_valid0, 0);

    // MT19937 from 5489, ready held high through 10000 words.
    reseed(0, 32'd5489, 10000);
    wait_run(0);
    stream(0, 10000, 1'b0);

    // Same stream under random long stalls.
    reseed(0, 32'd5489, 400);
    wait_run(0);
    stream(0, 400, 1'b1);

    // Reseed while a word is held under stall.
    reseed(0, 32'd5489, 100);
    wait_run(0);
    stream(0, 100, 1'b0);
    chk("held_valid_before_reseed", rv_valid0, 1);
    reseed(0, 32'd5489, 10);
    chk("valid_drops_after_reseed", rv_valid0, 0);
    stream(0, 10, 1'b0);

    // Abort seeding with seed 1 partway through, then seed 5489.
    reseed(0, 32'd1, 0);
    repeat (299) begin @(posedge clk); #1; end
    chk("busy_mid_seed", busy0, 1);
    reseed(0, 32'd5489, 20);
    wait_run(0);
    stream(0, 20, 1'b0);

    // Small variant with random seeds and stalls, including a mid-stall reseed.
    s_small = 32'($urandom_range(0, 65535));
    reseed(1, s_small, 150);
    wait_run(1);
    stream(1, 150, 1'b1);
    s_small = 32'($urandom_range(0, 65535));
    reseed(1, s_small, 300);
    wait_run(1);
    stream(1, 300, 1'b1);

    // Asynchronous reset while both instances are in RUN.
    #2 n_rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    chk("async_rst_valid0", rv_valid0, 0);
    chk("async_rst_rv0", rv0, 0);
    chk("async_rst_seeded0", seeded0, 0);
    chk("async_rst_busy0", busy0, 0);
    chk("async_rst_valid1", rv_valid1, 0);
    chk("async_rst_rv1", rv1, 0);
    chk("async_rst_seeded1", seeded1, 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    rr0 = 1'b1; rr1 = 1'b1;
    seen0 = 0; seen1 = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rv_valid0) seen0++;
      if (rv_valid1) seen1++;
    end
    chk("no_valid_after_rst0", seen0, 0);
    chk("no_valid_after_rst1", seen1, 0);
    chk("state_after_rst1", dbg1, ST_UNSEEDED);
    rr0 = 1'b0; rr1 = 1'b0;

    // Recovery after reset.
    s_small = 32'($urandom_range(0, 65535));
    reseed(1, s_small, 70);
    wait_run(1);
    stream(1, 70, 1'b0);

    repeat (3) begin @(posedge clk); #1; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
